// File: rtl/bus_master_pkg.sv
// Shared types and constants for the peripheral-bus master.
package bus_master_pkg;

    localparam int unsigned BUS_AW  = 32;
    localparam int unsigned BUS_DW  = 32;
    localparam int unsigned BUS_BEW = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_RESP
    } state_t;

    // Poll termination test: compare only the bits selected by mask.
    function automatic logic poll_match(
        input logic [BUS_DW-1:0] rd_data,
        input logic [BUS_DW-1:0] cmp_data,
        input logic [BUS_DW-1:0] mask
    );
        return ((rd_data & mask) == (cmp_data & mask));
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Load/clear saturating down-counter; expired while the count sits at zero.
module bus_watchdog #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic             tick,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load wins over clear; ticks stop at zero so the count never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/bus_master_seq.sv
// Single-outstanding command-to-bus master with hardware read-poll and a
// ready-timeout watchdog on every bus transaction.
module bus_master_seq
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic               cmd_poll,
    input  logic [BUS_AW-1:0]  cmd_addr,
    input  logic [BUS_DW-1:0]  cmd_data,
    input  logic [BUS_DW-1:0]  cmd_mask,
    input  logic [BUS_BEW-1:0] cmd_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BUS_DW-1:0]  rsp_data,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic               enable,
    output logic               wr_en,
    output logic [BUS_AW-1:0]  addr,
    output logic [BUS_DW-1:0]  i_data,
    output logic [BUS_BEW-1:0] be,
    input  logic               ready,
    input  logic [BUS_DW-1:0]  o_data,
    input  logic               bus_err
);

    // Watchdog is loaded with TIMEOUT-1 on the edge that raises enable, so it
    // reads zero on the TIMEOUT-th enable cycle.
    localparam logic [15:0] WD_LOAD    = 16'(TIMEOUT - 1);
    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    state_t             state;
    logic               out_of_reset;
    logic               cmd_poll_q;
    logic [BUS_DW-1:0]  cmd_data_q;
    logic [BUS_DW-1:0]  cmd_mask_q;
    logic [BUS_DW-1:0]  rd_data_q;
    logic               rd_err_q;
    logic [15:0]        attempts;

    logic accept;
    logic finish_ok;
    logic retry;
    logic wd_load;
    logic wd_clear;
    logic wd_tick;
    logic wd_expired;

    assign cmd_ready = (state == ST_IDLE) && out_of_reset;

    // Decode of handshakes, poll outcome and watchdog controls.
    always_comb begin
        accept    = cmd_valid && cmd_ready;
        finish_ok = !cmd_poll_q || rd_err_q || poll_match(rd_data_q, cmd_data_q, cmd_mask_q);
        retry     = !finish_ok && (attempts < POLL_LIMIT);
        wd_load   = ((state == ST_IDLE) && accept) || ((state == ST_CHECK) && retry);
        wd_clear  = (state == ST_RESP);
        wd_tick   = ((state == ST_ISSUE) || (state == ST_WAIT)) && !ready;
    end

    bus_watchdog #(
        .WIDTH (16)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .clear    (wd_clear),
        .tick     (wd_tick),
        .expired  (wd_expired)
    );

    // Main sequencer; bus and response outputs are registered here.
    // enable rises on the accept/retry edge itself, so ISSUE is the first
    // enable cycle and must already honour a zero-wait ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            out_of_reset <= 1'b0;
            enable       <= 1'b0;
            wr_en        <= 1'b0;
            addr         <= '0;
            i_data       <= '0;
            be           <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            rsp_timeout  <= 1'b0;
            cmd_poll_q   <= 1'b0;
            cmd_data_q   <= '0;
            cmd_mask_q   <= '0;
            rd_data_q    <= '0;
            rd_err_q     <= 1'b0;
            attempts     <= '0;
        end else begin
            out_of_reset <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        enable     <= 1'b1;
                        wr_en      <= cmd_wr && !cmd_poll;
                        addr       <= cmd_addr;
                        i_data     <= (cmd_wr && !cmd_poll) ? cmd_data : '0;
                        be         <= cmd_be;
                        cmd_poll_q <= cmd_poll;
                        cmd_data_q <= cmd_data;
                        cmd_mask_q <= cmd_mask;
                        attempts   <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (ready) begin
                        enable    <= 1'b0;
                        rd_data_q <= wr_en ? '0 : o_data;
                        rd_err_q  <= bus_err;
                        if (cmd_poll_q) begin
                            attempts <= attempts + 16'd1;
                        end
                        state <= ST_CHECK;
                    end else if (wd_expired) begin
                        enable      <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_CHECK: begin
                    if (finish_ok) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= rd_data_q;
                        rsp_err     <= rd_err_q;
                        rsp_timeout <= 1'b0;
                        state       <= ST_RESP;
                    end else if (retry) begin
                        enable <= 1'b1;
                        state  <= ST_ISSUE;
                    end else begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq with a behavioural slave and a
// response scoreboard.
module tb_bus_master_seq;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        tmo;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr, cmd_poll;
    logic [31:0] cmd_addr, cmd_data, cmd_mask;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_data;
    logic        enable, wr_en;
    logic [31:0] addr, i_data;
    logic [3:0]  be;
    logic        ready, bus_err;
    logic [31:0] o_data;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bus_master_seq #(
        .TIMEOUT  (8),
        .POLL_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wr      (cmd_wr),
        .cmd_poll    (cmd_poll),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .cmd_be      (cmd_be),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .enable      (enable),
        .wr_en       (wr_en),
        .addr        (addr),
        .i_data      (i_data),
        .be          (be),
        .ready       (ready),
        .o_data      (o_data),
        .bus_err     (bus_err)
    );

    rsp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Slave model and bus monitor, both evaluated at negedge.
    int          slave_wait = 0;
    logic        slave_err  = 1'b0;
    logic [31:0] slave_q[$];
    int          wcnt = 0, txn_count = 0, en_len = 0, last_en_len = 0;
    int          gap = 1000, min_gap = 1000, ready_cyc = 0;
    logic        en_prev = 1'b0, unstable = 1'b0;
    logic [31:0] cap_addr = '0, cap_idata = '0;
    logic        cap_wr = 1'b0;
    logic [3:0]  cap_be = '0;

    initial begin
        ready   = 1'b0;
        o_data  = '0;
        bus_err = 1'b0;
        forever begin
            @(negedge clk);
            if (enable) begin
                if (!en_prev) begin
                    txn_count++;
                    en_len = 0;
                    if (gap < min_gap) min_gap = gap;
                    cap_addr = addr; cap_idata = i_data; cap_wr = wr_en; cap_be = be;
                end else if (addr !== cap_addr || i_data !== cap_idata || wr_en !== cap_wr || be !== cap_be) begin
                    unstable = 1'b1;
                end
                gap = 0;
                en_len++;
                if (slave_wait >= 0 && wcnt == slave_wait) begin
                    ready     = 1'b1;
                    o_data    = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                    bus_err   = slave_err;
                    ready_cyc = cyc;
                end else begin
                    ready = 1'b0;
                    wcnt++;
                end
            end else begin
                if (en_prev) last_en_len = en_len;
                ready   = 1'b0;
                o_data  = '0;
                bus_err = 1'b0;
                wcnt    = 0;
                gap++;
            end
            en_prev = enable;
        end
    end

    task automatic send_cmd(input logic wr, input logic poll, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] m, input logic [3:0] b,
                            output int acc, output bit ok);
        @(negedge clk);
        cmd_wr = wr; cmd_poll = poll; cmd_addr = a; cmd_data = d; cmd_mask = m; cmd_be = b;
        cmd_valid = 1'b1;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) begin
                ok  = 1'b1;
                acc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic collect_rsp(input int hold, output rsp_t obs, output int vcyc,
                               output bit ok, output bit stable, output bit crdy_seen);
        ok = 1'b0; stable = 1'b1; crdy_seen = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) ok = 1'b1;
        end
        vcyc = cyc;
        obs  = '{data: rsp_data, err: rsp_err, tmo: rsp_timeout};
        if (ok) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_data !== obs.data || rsp_err !== obs.err ||
                    rsp_timeout !== obs.tmo) stable = 1'b0;
                if (cmd_ready !== 1'b0) crdy_seen = 1'b1;
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
        end
        n_checks++;
        if ({enable, wr_en, addr, i_data, be} !== 70'h0) begin
            n_fail++; $display("FAIL reset_bus: got en=%b wr=%b addr=%h data=%h be=%h expected all 0",
                               enable, wr_en, addr, i_data, be);
        end
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_err, rsp_timeout} !== 35'h0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b d=%h e=%b t=%b expected all 0",
                               rsp_valid, rsp_data, rsp_err, rsp_timeout);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        rsp_t obs, exp;
        int acc, vcyc, t0;
        bit ok, okr, st, cr;
        slave_wait = 2; slave_err = 1'b0; unstable = 1'b0; t0 = txn_count;
        sb.push_back('{data: 32'h0, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b1, 1'b0, 32'h04, 32'hFF, 32'h0, 4'b1111, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr)) begin
            n_fail++; $display("FAIL write_handshake: got accept=%b rsp=%b expected 1 1", ok, okr);
        end
        n_checks++;
        if ({cap_wr, cap_addr, cap_idata, cap_be} !== {1'b1, 32'h04, 32'hFF, 4'hF}) begin
            n_fail++; $display("FAIL write_fields: got wr=%b addr=%h data=%h be=%h expected 1 00000004 000000ff f",
                               cap_wr, cap_addr, cap_idata, cap_be);
        end
        n_checks++;
        if (unstable !== 1'b0 || txn_count - t0 != 1 || last_en_len != 3) begin
            n_fail++; $display("FAIL write_bus_cycle: got unstable=%b txns=%0d en_len=%0d expected 0 1 3",
                               unstable, txn_count - t0, last_en_len);
        end
        n_checks++;
        if (vcyc - ready_cyc != 2) begin
            n_fail++; $display("FAIL write_ready_to_rsp: got %0d expected 2", vcyc - ready_cyc);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL write_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_read_zero_wait();
        rsp_t obs, exp;
        int acc, vcyc;
        bit ok, okr, st, cr;
        slave_wait = 0; unstable = 1'b0;
        slave_q.push_back(32'h0000_1234);
        sb.push_back('{data: 32'h0000_1234, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 4'b0011, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr) || vcyc - acc != 3) begin
            n_fail++; $display("FAIL read_latency: got ok=%b%b cycles=%0d expected 11 3", ok, okr, vcyc - acc);
        end
        n_checks++;
        if ({cap_wr, cap_addr, cap_idata, cap_be} !== {1'b0, 32'h10, 32'h0, 4'b0011}) begin
            n_fail++; $display("FAIL read_fields: got wr=%b addr=%h data=%h be=%h expected 0 00000010 00000000 3",
                               cap_wr, cap_addr, cap_idata, cap_be);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL read_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_poll();
        rsp_t obs, exp;
        int acc, vcyc, t0;
        bit ok, okr, st, cr;
        slave_wait = 1; min_gap = 1000; t0 = txn_count;
        slave_q.push_back(32'h0); slave_q.push_back(32'h0); slave_q.push_back(32'h1);
        sb.push_back('{data: 32'h1, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b1, 1'b1, 32'h20, 32'h1, 32'h1, 4'hF, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr) || txn_count - t0 != 3) begin
            n_fail++; $display("FAIL poll_reads: got ok=%b%b reads=%0d expected 11 3", ok, okr, txn_count - t0);
        end
        n_checks++;
        if (min_gap < 1 || cap_wr !== 1'b0 || cap_idata !== 32'h0) begin
            n_fail++; $display("FAIL poll_bus: got gap=%0d wr=%b data=%h expected >=1 0 00000000",
                               min_gap, cap_wr, cap_idata);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL poll_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_poll_exhaust();
        rsp_t obs, exp;
        int acc, vcyc, t0;
        bit ok, okr, st, cr;
        slave_wait = 0; min_gap = 1000; t0 = txn_count;
        for (int i = 0; i < 6; i++) slave_q.push_back(32'hFFFF_FFF0);
        sb.push_back('{data: 32'h0, err: 1'b0, tmo: 1'b1});
        send_cmd(1'b0, 1'b1, 32'h24, 32'h5, 32'hF, 4'hF, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        slave_q.delete();
        n_checks++;
        if (!(ok && okr) || txn_count - t0 != 4 || min_gap < 1) begin
            n_fail++; $display("FAIL poll_exhaust_reads: got ok=%b%b reads=%0d gap=%0d expected 11 4 >=1",
                               ok, okr, txn_count - t0, min_gap);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL poll_exhaust_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_timeout();
        rsp_t obs, exp;
        int acc, vcyc;
        bit ok, okr, st, cr;
        slave_wait = -1;
        sb.push_back('{data: 32'h0, err: 1'b0, tmo: 1'b1});
        send_cmd(1'b0, 1'b0, 32'h30, 32'h0, 32'h0, 4'hF, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr) || last_en_len != 8) begin
            n_fail++; $display("FAIL timeout_enable_len: got ok=%b%b len=%0d expected 11 8", ok, okr, last_en_len);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL timeout_rsp: got %h expected %h", obs, exp);
        end
        slave_wait = 7;
        slave_q.push_back(32'h0000_0055);
        sb.push_back('{data: 32'h55, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 1'b0, 32'h34, 32'h0, 32'h0, 4'hF, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr) || last_en_len != 8) begin
            n_fail++; $display("FAIL edge_ready_len: got ok=%b%b len=%0d expected 11 8", ok, okr, last_en_len);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL edge_ready_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_bus_err_backpressure();
        rsp_t obs, exp;
        int acc, vcyc;
        bit ok, okr, st, cr;
        slave_wait = 1; slave_err = 1'b1;
        sb.push_back('{data: 32'h0, err: 1'b1, tmo: 1'b0});
        send_cmd(1'b1, 1'b0, 32'h40, 32'hA5A5_0000, 32'h0, 4'b1100, acc, ok);
        collect_rsp(5, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        slave_err = 1'b0;
        n_checks++;
        if (!(ok && okr) || st !== 1'b1 || cr !== 1'b0) begin
            n_fail++; $display("FAIL hold_stable: got ok=%b%b stable=%b cmd_ready_seen=%b expected 11 1 0",
                               ok, okr, st, cr);
        end
        n_checks++;
        if (obs !== exp) begin
            n_fail++; $display("FAIL bus_err_rsp: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t obs, exp;
        int acc, vcyc;
        bit ok, okr, st, cr, seen;
        slave_wait = -1;
        send_cmd(1'b0, 1'b0, 32'h50, 32'h0, 32'h0, 4'hF, acc, ok);
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || enable !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_enable: got ok=%b enable=%b expected 1 1", ok, enable);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (enable !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_drop: got enable=%b rsp_valid=%b expected 0 0", enable, rsp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || enable !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got activity=%b expected 0", seen);
        end
        slave_wait = 0;
        slave_q.push_back(32'h0000_CAFE);
        sb.push_back('{data: 32'hCAFE, err: 1'b0, tmo: 1'b0});
        send_cmd(1'b0, 1'b0, 32'h54, 32'h0, 32'h0, 4'hF, acc, ok);
        collect_rsp(0, obs, vcyc, okr, st, cr);
        exp = sb.pop_front();
        n_checks++;
        if (!(ok && okr) || obs !== exp) begin
            n_fail++; $display("FAIL after_reset_rsp: got ok=%b%b rsp=%h expected 11 %h", ok, okr, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_poll = 1'b0;
        cmd_addr = '0; cmd_data = '0; cmd_mask = '0; cmd_be = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_zero_wait();
        test_poll();
        test_poll_exhaust();
        test_timeout();
        test_bus_err_backpressure();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_master_seq.md
# bus_master_seq

Single-outstanding bus master that turns a valid/ready command stream into transactions on the peripheral bus used by `timer_mem` (enable/wr_en/addr/i_data/be in, ready/o_data/bus_err out). It sits directly upstream of the peripheral and replaces hand-written per-register state machines in top-level designs. It returns one response per command. It supports a hardware poll command: repeat a read until masked data matches. Every transaction is guarded by a ready-timeout watchdog.

## Interface
- `TIMEOUT`, default 255: max cycles `enable` is held without `ready` before abort; 1..65535.
- `POLL_MAX`, default 1023: max read attempts per poll command; 1..65535.
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_wr` in 1: 1 = write, 0 = read.
- `cmd_poll` in 1: read-poll command; `cmd_wr` is ignored when set.
- `cmd_addr` in 32: bus address.
- `cmd_data` in 32: write data, or poll compare value.
- `cmd_mask` in 32: poll mask; ignored otherwise.
- `cmd_be` in 4: byte enables, passed through.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_data` out 32: read data (last read for poll); 0 for writes, timeouts and poll-exhausted responses.
- `rsp_err` out 1: slave returned `bus_err`.
- `rsp_timeout` out 1: ready watchdog expired, or poll attempts exhausted.
- `enable`, `wr_en` out 1 each: bus request and direction.
- `addr` out 32, `i_data` out 32, `be` out 4: bus request fields.
- `ready` in 1, `o_data` in 32, `bus_err` in 1: slave completion.

## Operation
- States:
  - IDLE: `cmd_ready`=1. On accept, latch the command and go to ISSUE.
  - ISSUE: drive `enable`=1 plus the request fields, clear the watchdog, go to WAIT.
  - WAIT: hold `enable` and all fields stable.
    - If `ready`=1: capture `o_data` and `bus_err`, drop `enable` on the next edge, go to CHECK.
    - Else if the watchdog reaches `TIMEOUT`: drop `enable` and go to RESP with `rsp_timeout`=1.
  - CHECK:
    - Non-poll command: go to RESP.
    - Poll with `bus_err`: go to RESP with `rsp_err`=1.
    - Poll where `(o_data & cmd_mask) == (cmd_data & cmd_mask)`: go to RESP.
    - Poll, no match, attempts < `POLL_MAX`: increment attempts, go to ISSUE.
    - Poll, no match, attempts exhausted: go to RESP with `rsp_timeout`=1 and `rsp_data`=0.
  - RESP: `rsp_valid`=1 and response fields stable until `rsp_ready`; then go to IDLE.
- `enable` is only ever 1 in ISSUE/WAIT.
- `i_data` is forced to 0 on reads and polls.
- `bus_err` is sampled only in the `ready` cycle. On a write it sets `rsp_err`; on a read it sets `rsp_err` and still returns `o_data`.
- Watchdog: 16-bit counter, saturating. It never wraps.
- Poll attempt counter: 16 bits, cleared on command accept.
- `rsp_err` and `rsp_timeout` are never both 1.

## Timing
- Reset: all outputs 0 (`cmd_ready`=0 during reset, 1 the first cycle after). State goes to IDLE and counters clear. Reset mid-transaction drops `enable` at that edge with no response; the peripheral shares `rst`.
- Accept at edge N → `enable`=1 from N+1. `ready` sampled high at edge M → `enable`=0 from M+1, `rsp_valid`=1 from M+2.
- Zero-wait slave (`ready` in the first enable cycle): accept to `rsp_valid` = 3 cycles.
- Consecutive transactions always have at least 1 cycle of `enable`=0 between them, including poll retries.
- Timeout: `enable` high for exactly `TIMEOUT` cycles, then low. A `ready` arriving on the same edge the watchdog expires wins: normal completion.
- `cmd_ready` is combinational from state only, with no dependence on `cmd_valid`. There is no command buffering.

## Structure
- Package `bus_master_pkg`:
  - state encoding localparams (IDLE, ISSUE, WAIT, CHECK, RESP);
  - `BUS_AW`=32, `BUS_DW`=32, `BUS_BEW`=4.
- One sub-module, `bus_watchdog`: a load/clear saturating down-counter with an `expired` flag. It is used for the ready timeout and is reusable by other masters.

## Test plan
- Write at addr 0x04, data 0xFF, `be` 4'b1111, slave `ready` after 2 wait cycles → one bus cycle with exact fields; `rsp_valid` 2 cycles after `ready`; `rsp_data`=0, no flags.
- Read at addr 0x10, `be` 4'b0011, slave returns 0x0000_1234 with zero wait → `rsp_data`=0x1234, accept→`rsp_valid`=3 cycles, `i_data`=0.
- Poll: mask 0x1, value 0x1, slave returns 0,0,1 → exactly 3 bus reads, each separated by ≥1 idle cycle; `rsp_data`=1, no flags.
- `TIMEOUT`=8, slave never ready → `enable` high exactly 8 cycles, then `rsp_timeout`=1, `rsp_data`=0. Repeat with `ready` on the 8th cycle → normal completion.
- `bus_err`=1 with `ready` on a write → `rsp_err`=1. Hold `rsp_ready`=0 for 5 cycles → `cmd_ready`=0 and all response fields stable throughout.
- Assert `rst` in WAIT → `enable`=0 at the next edge, no `rsp_valid`. The next command after reset completes normally.
